// File: rtl/gsensor_filter.sv
// Per-axis boxcar smoother for accelerometer samples with
// hysteretic tilt classification of each filtered axis.
module gsensor_filter #(
  parameter int LOG2_DEPTH = 3,
  parameter int TILT_ON    = 64,
  parameter int TILT_OFF   = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        data_valid,
  input  logic [15:0] data_x,
  input  logic [15:0] data_y,
  input  logic [15:0] data_z,
  output logic        avg_valid,
  output logic [15:0] avg_x,
  output logic [15:0] avg_y,
  output logic [15:0] avg_z,
  output logic [1:0]  tilt_x,
  output logic [1:0]  tilt_y,
  output logic [1:0]  tilt_z,
  output logic        filled
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SW    = 16 + LOG2_DEPTH;
  localparam int CW    = LOG2_DEPTH + 1;

  typedef enum logic [1:0] {
    LEVEL = 2'b00,
    POS   = 2'b01,
    NEG   = 2'b10
  } tilt_e;

  logic [LOG2_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  sum_vld_q;
  logic                  avg_valid_q;
  logic                  full;

  logic [2:0][15:0] din;
  logic [2:0][15:0] avg_all;
  logic [2:0][1:0]  tilt_all;

  assign din  = {data_z, data_y, data_x};
  assign full = (count_q == CW'(DEPTH));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (data_valid) begin
      wr_ptr_d = wr_ptr_q + LOG2_DEPTH'(1);
      if (!full) count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      count_q     <= '0;
      sum_vld_q   <= 1'b0;
      avg_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      sum_vld_q   <= data_valid;
      avg_valid_q <= sum_vld_q;
    end
  end

  for (genvar a = 0; a < 3; a++) begin : g_axis
    logic signed [15:0]   mem_q [DEPTH];
    logic signed [15:0]   smp;
    logic signed [15:0]   oldest;
    logic signed [SW-1:0] sum_q, sum_d;
    logic signed [15:0]   avg_q, avg_d;
    tilt_e                tilt_q, tilt_d;

    assign smp = din[a];
    // Buffer is never cleared, so stale entries are masked until full.
    assign oldest = full ? mem_q[wr_ptr_q] : '0;

    always_ff @(posedge clk) begin
      if (reset_n && data_valid) mem_q[wr_ptr_q] <= smp;
    end

    always_comb begin
      sum_d = sum_q;
      if (data_valid) begin
        sum_d = sum_q
              + {{LOG2_DEPTH{smp[15]}}, smp}
              - {{LOG2_DEPTH{oldest[15]}}, oldest};
      end
    end

    always_comb begin
      avg_d = avg_q;
      if (sum_vld_q) avg_d = 16'(sum_q >>> LOG2_DEPTH);
    end

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        sum_q  <= '0;
        avg_q  <= '0;
        tilt_q <= LEVEL;
      end else begin
        sum_q  <= sum_d;
        avg_q  <= avg_d;
        tilt_q <= tilt_d;
      end
    end

    always_comb begin
      tilt_d = tilt_q;
      if (sum_vld_q) begin
        unique case (tilt_q)
          LEVEL: begin
            if (avg_d > TILT_ON)       tilt_d = POS;
            else if (avg_d < -TILT_ON) tilt_d = NEG;
          end
          POS: begin
            if (avg_d < -TILT_ON)      tilt_d = NEG;
            else if (avg_d < TILT_OFF) tilt_d = LEVEL;
          end
          NEG: begin
            if (avg_d > TILT_ON)        tilt_d = POS;
            else if (avg_d > -TILT_OFF) tilt_d = LEVEL;
          end
          default: tilt_d = LEVEL;
        endcase
      end
    end

    always_comb begin
      avg_all[a]  = avg_q;
      tilt_all[a] = tilt_q;
    end
  end

  assign avg_valid = avg_valid_q;
  assign avg_x     = avg_all[0];
  assign avg_y     = avg_all[1];
  assign avg_z     = avg_all[2];
  assign tilt_x    = tilt_all[0];
  assign tilt_y    = tilt_all[1];
  assign tilt_z    = tilt_all[2];
  assign filled    = full;

endmodule

// File: tb/tb_gsensor_filter.sv
// Directed bench for gsensor_filter: three instances at
// window depths 2, 4 and 8 share one stimulus stream.
module tb_gsensor_filter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        data_valid = 1'b0;
  logic [15:0] dx = '0;
  logic [15:0] dy = '0;
  logic [15:0] dz = '0;

  logic [2:0]       av, fl;
  logic [2:0][15:0] ax, ay, az;
  logic [2:0][1:0]  tx, ty, tz;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gsensor_filter #(.LOG2_DEPTH(1)) u_d1 (
    .clk(clk), .reset_n(reset_n), .data_valid(data_valid),
    .data_x(dx), .data_y(dy), .data_z(dz),
    .avg_valid(av[0]),
    .avg_x(ax[0]), .avg_y(ay[0]), .avg_z(az[0]),
    .tilt_x(tx[0]), .tilt_y(ty[0]), .tilt_z(tz[0]),
    .filled(fl[0])
  );

  gsensor_filter #(.LOG2_DEPTH(2)) u_d2 (
    .clk(clk), .reset_n(reset_n), .data_valid(data_valid),
    .data_x(dx), .data_y(dy), .data_z(dz),
    .avg_valid(av[1]),
    .avg_x(ax[1]), .avg_y(ay[1]), .avg_z(az[1]),
    .tilt_x(tx[1]), .tilt_y(ty[1]), .tilt_z(tz[1]),
    .filled(fl[1])
  );

  gsensor_filter #(.LOG2_DEPTH(3)) u_d3 (
    .clk(clk), .reset_n(reset_n), .data_valid(data_valid),
    .data_x(dx), .data_y(dy), .data_z(dz),
    .avg_valid(av[2]),
    .avg_x(ax[2]), .avg_y(ay[2]), .avg_z(az[2]),
    .tilt_x(tx[2]), .tilt_y(ty[2]), .tilt_z(tz[2]),
    .filled(fl[2])
  );

  typedef struct {
    bit rst;
    int l;
    int x;
    int avg;
    int tilt;
    bit fl;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(bit r, int l, int x,
                              int a, int t, bit f);
    vec_t v;
    v.rst  = r;
    v.l    = l;
    v.x    = x;
    v.avg  = a;
    v.tilt = t;
    v.fl   = f;
    return v;
  endfunction

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    data_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic drive(input int x);
    dx = 16'(x);
    dy = dx;
    dz = dx;
  endtask

  task automatic apply(input vec_t v, input int i);
    int k;
    k = v.l - 1;
    if (v.rst) do_reset();
    data_valid = 1'b1;
    drive(v.x);
    @(posedge clk);
    #1 data_valid = 1'b0;
    chk($sformatf("v%0d gap", i), int'(av[k]), 0);
    @(posedge clk);
    #1;
    chk($sformatf("v%0d valid", i), int'(av[k]), 1);
    chk($sformatf("v%0d avg_x", i), $signed(ax[k]), v.avg);
    chk($sformatf("v%0d avg_y", i), $signed(ay[k]), v.avg);
    chk($sformatf("v%0d avg_z", i), $signed(az[k]), v.avg);
    chk($sformatf("v%0d tilt_x", i), int'(tx[k]), v.tilt);
    chk($sformatf("v%0d tilt_y", i), int'(ty[k]), v.tilt);
    chk($sformatf("v%0d tilt_z", i), int'(tz[k]), v.tilt);
    chk($sformatf("v%0d filled", i), int'(fl[k]), int'(v.fl));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bb_exp [8];
    bb_exp = '{0, 0, 1, 2, 3, 4, 5, 6};

    // warm-up then wrap, depth 4
    tv.push_back(mk(1, 2, 100,  25, 0, 0));
    tv.push_back(mk(0, 2, 100,  50, 0, 0));
    tv.push_back(mk(0, 2, 100,  75, 1, 0));
    tv.push_back(mk(0, 2, 100, 100, 1, 1));
    tv.push_back(mk(0, 2,   0,  75, 1, 1));
    tv.push_back(mk(0, 2,   0,  50, 1, 1));
    tv.push_back(mk(0, 2,   0,  25, 0, 1));
    tv.push_back(mk(0, 2,   0,   0, 0, 1));
    // negative rounding and extreme values, depth 2
    tv.push_back(mk(1, 1,     -3,     -2, 0, 0));
    tv.push_back(mk(0, 1,     -3,     -3, 0, 1));
    tv.push_back(mk(0, 1, -32768, -16386, 2, 1));
    tv.push_back(mk(0, 1, -32768, -32768, 2, 1));
    // hysteresis walk, depth 2
    tv.push_back(mk(1, 1,  70,  35, 0, 0));
    tv.push_back(mk(0, 1,  70,  70, 1, 1));
    tv.push_back(mk(0, 1,  40,  55, 1, 1));
    tv.push_back(mk(0, 1,  40,  40, 1, 1));
    tv.push_back(mk(0, 1,  20,  30, 0, 1));
    tv.push_back(mk(0, 1,  20,  20, 0, 1));
    tv.push_back(mk(0, 1, -70, -25, 0, 1));
    tv.push_back(mk(0, 1, -70, -70, 2, 1));
    tv.push_back(mk(0, 1, -40, -55, 2, 1));
    tv.push_back(mk(0, 1, -40, -40, 2, 1));
    tv.push_back(mk(0, 1, -20, -30, 0, 1));
    tv.push_back(mk(0, 1, -20, -20, 0, 1));
    // direct POS->NEG->POS, depth 2
    tv.push_back(mk(1, 1,   70,  35, 0, 0));
    tv.push_back(mk(0, 1,   70,  70, 1, 1));
    tv.push_back(mk(0, 1, -210, -70, 2, 1));
    tv.push_back(mk(0, 1,  350,  70, 1, 1));

    do_reset();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst valid d%0d", k), int'(av[k]), 0);
      chk($sformatf("rst filled d%0d", k), int'(fl[k]), 0);
      chk($sformatf("rst avg d%0d", k), int'(ax[k]), 0);
      chk($sformatf("rst tilt d%0d", k), int'(tx[k]), 0);
    end

    foreach (tv[i]) apply(tv[i], i);

    // back-to-back 1..8 into depth 4
    do_reset();
    for (int c = 0; c < 12; c++) begin
      data_valid = (c < 8);
      drive(c + 1);
      chk($sformatf("bb valid c%0d", c), int'(av[1]),
          int'(c >= 2 && c < 10));
      if (c >= 2 && c < 10)
        chk($sformatf("bb avg c%0d", c), $signed(ax[1]),
            bb_exp[c-2]);
      @(posedge clk);
      #1;
    end
    chk("bb final avg", $signed(ax[1]), 6);
    chk("bb filled", int'(fl[1]), 1);

    // reset one cycle after a sample; sample during reset ignored
    do_reset();
    data_valid = 1'b1;
    drive(50);
    @(posedge clk);
    #1;
    drive(99);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    reset_n    = 1'b1;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("mr valid d3 c%0d", c), int'(av[2]), 0);
      chk($sformatf("mr valid d1 c%0d", c), int'(av[0]), 0);
      @(posedge clk);
      #1;
    end
    chk("mr avg", int'(ax[2]), 0);
    chk("mr tilt", int'(tx[2]), 0);
    chk("mr filled", int'(fl[2]), 0);
    apply(mk(0, 3, 8, 1, 0, 0), 100);
    chk("mr d1 avg", $signed(ax[0]), 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gsensor_filter.md
# gsensor_filter

Downstream consumer of the accelerometer sampler. Takes each `data_valid`-qualified X/Y/Z sample and smooths every axis with a power-of-two boxcar (moving-average) filter. Classifies each filtered axis into a hysteretic tilt state (level / positive / negative). Feeds LED and seven-segment display logic and game/control logic that need stable orientation instead of raw, noisy samples.

## Interface
- `LOG2_DEPTH`, 3: window = 2^LOG2_DEPTH samples per axis; legal range 1..6.
- `TILT_ON`, 64: magnitude (LSB of filtered value) that enters a tilt state; 64 = 0.25 g at 256 LSB/g.
- `TILT_OFF`, 32: magnitude below which a tilt state returns to level; must satisfy 0 ≤ TILT_OFF < TILT_ON.
- `clk`  in  1  clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `data_valid`  in  1  one-cycle strobe; X/Y/Z sample present.
- `data_x`, `data_y`, `data_z`  in  16 each  two's-complement raw samples.
- `avg_valid`  out  1  one-cycle strobe; averages and tilt outputs updated.
- `avg_x`, `avg_y`, `avg_z`  out  16 each  signed filtered values.
- `tilt_x`, `tilt_y`, `tilt_z`  out  2 each  2'b00 level, 2'b01 positive, 2'b10 negative; 2'b11 never driven.
- `filled`  out  1  high once the window holds DEPTH real samples.

## Operation
- Per-axis storage:
  - Ring buffer of DEPTH × 16-bit entries.
  - Running sum, signed, 16+LOG2_DEPTH bits.
  - One shared write pointer, LOG2_DEPTH bits, wraps DEPTH−1 → 0.
- Fill counter:
  - Width LOG2_DEPTH+1; increments on each accepted sample; saturates at DEPTH.
  - `filled` = (count == DEPTH).
- Stage 1, on the `data_valid` cycle:
  - Capture the new sample.
  - Read the oldest entry at `wr_ptr`. Use 0 instead if count < DEPTH, because buffer contents are not cleared by reset.
  - Write the new sample at `wr_ptr`; then increment `wr_ptr` and `count`.
- Stage 2:
  - sum ← sum + sext(new) − sext(oldest).
  - No overflow is possible at this width.
- Stage 3:
  - avg ← sum >>> LOG2_DEPTH (arithmetic shift, floor toward −∞), truncated to 16 bits.
  - Tilt state updated from the new avg; `avg_valid` asserted.
- Pipelining:
  - Fully pipelined; one sample accepted per cycle, back-to-back `data_valid` supported.
  - No read/write collision because LOG2_DEPTH ≥ 1.
- Tilt FSM per axis, evaluated only when a new avg is produced, using signed compares:
  - LEVEL → POS if avg > TILT_ON.
  - LEVEL → NEG if avg < −TILT_ON.
  - POS → NEG if avg < −TILT_ON.
  - POS → LEVEL if avg < TILT_OFF (and not < −TILT_ON).
  - NEG → POS if avg > TILT_ON.
  - NEG → LEVEL if avg > −TILT_OFF (and not > TILT_ON).
  - Otherwise hold.
- Warm-up: before `filled`, avg = (sum of received samples)/DEPTH, biased toward 0. The tilt FSM runs regardless; consumers gate on `filled` if needed.

## Timing
- Latency: `data_valid` at cycle N → `avg_valid` pulse and updated avg/tilt registers at cycle N+2.
- `avg_valid` is high for exactly one cycle per accepted sample; outputs hold between pulses.
- `filled` rises at cycle N+1 after the DEPTH-th sample's `data_valid` at cycle N.
- Reset values (reset_n low at a clock edge):
  - avg_* = 0, tilt_* = 2'b00, avg_valid = 0, filled = 0.
  - sums = 0, wr_ptr = 0, count = 0.
  - All pipeline valid bits = 0.
- Reset mid-pipeline:
  - Samples in flight are discarded; no `avg_valid` is produced for them after reset releases.
  - A `data_valid` coincident with reset_n low is ignored.
- Inputs are sampled only on `data_valid` cycles; data is don't-care otherwise.

## Test plan
- Warm-up, LOG2_DEPTH=2: four samples of x=100.
  - avg_x = 25, 50, 75, 100.
  - `filled` high after the 4th sample; each `avg_valid` exactly 2 cycles after its `data_valid`.
- Wrap-around, LOG2_DEPTH=2: samples x = 100, 100, 100, 100, 0, 0, 0, 0.
  - After fill, avg_x = 75, 50, 25, 0; `wr_ptr` wraps cleanly.
- Negative rounding, LOG2_DEPTH=1: samples x = −3, −3.
  - avg_x = −2 (floor of −1.5), then −3.
  - Sample −32768 ×2 → −32768, no overflow.
- Back-to-back: 8 consecutive `data_valid` cycles with x = 1..8, LOG2_DEPTH=2.
  - 8 consecutive `avg_valid` pulses; final avg_x = (5+6+7+8)>>2 = 6.
- Hysteresis, LOG2_DEPTH=1, defaults: hold x steady so avg_x steps through 70, 40, 20, −70, −40, −20.
  - tilt_x = 01, 01, 00, 10, 10, 00.
  - Direct POS→NEG: avg 70 then −70 gives 01 then 10.
- Reset mid-stream: assert reset_n low 1 cycle after `data_valid`.
  - No `avg_valid` follows; all outputs 0, `filled` 0.
  - Next sample x=8, LOG2_DEPTH=3, gives avg_x = 1.
